// File: rtl/floo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : floo_pkg
//  Description : Shared FlooNoC types for the multicast response reducer:
//                flit header layout, AXI response encoding, table entry.
//  Revision    : 1.0 - initial multicast response reduction support
// ============================================================================
package floo_pkg;

    localparam int unsigned MaxDestsDefault    = 16;
    localparam int unsigned NumMcastIdsDefault = 8;
    localparam int unsigned McastIdWidth       = $clog2(NumMcastIdsDefault);
    localparam int unsigned McastCntWidth      = $clog2(MaxDestsDefault + 1);
    localparam int unsigned PayloadWidth       = 32;

    // AXI response codes; numeric order doubles as severity order.
    typedef enum logic [1:0] {
        RespOkay   = 2'd0,
        RespExOkay = 2'd1,
        RespSlvErr = 2'd2,
        RespDecErr = 2'd3
    } rsp_err_e;

    typedef struct packed {
        logic                    ring_on_mesh_mcast;
        logic [McastIdWidth-1:0] mcast_id;
        rsp_err_e                rsp_err;
    } hdr_t;

    typedef struct packed {
        hdr_t                    hdr;
        logic [PayloadWidth-1:0] payload;
    } flit_t;

    typedef struct packed {
        logic [McastCntWidth-1:0] cnt;
        rsp_err_e                 err;
    } mcast_entry_t;

    // Merge two responses: the more severe code wins.
    function automatic rsp_err_e rsp_err_max(input rsp_err_e a, input rsp_err_e b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/floo_mcast_rsp_table.sv
`default_nettype none
// ============================================================================
//  Module      : floo_mcast_rsp_table
//  Description : Per-multicast-id collection state (response count and
//                merged error) with lookup, update, clear and a count of
//                entries currently collecting.
//  Revision    : 1.0 - initial version
// ============================================================================
module floo_mcast_rsp_table
    import floo_pkg::*;
#(
    parameter int unsigned NumMcastIds = 8,
    parameter int unsigned IdWidth     = 3,
    parameter int unsigned PendWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [IdWidth-1:0]   lookup_id,
    output mcast_entry_t         lookup_entry,
    input  logic                 upd_en,
    input  logic                 clr_en,
    input  logic [IdWidth-1:0]   upd_id,
    input  mcast_entry_t         upd_entry,
    output logic [PendWidth-1:0] pending
);

    mcast_entry_t entries [NumMcastIds];

    // Entry storage: clear wins over update (a flit is either final or absorbed).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumMcastIds); i++) begin
                entries[i] <= '0;
            end
        end else if (clr_en) begin
            entries[upd_id] <= '0;
        end else if (upd_en) begin
            entries[upd_id] <= upd_entry;
        end
    end

    assign lookup_entry = entries[lookup_id];

    // Number of ids with at least one response collected.
    always_comb begin
        pending = '0;
        for (int i = 0; i < int'(NumMcastIds); i++) begin
            if (entries[i].cnt != '0) begin
                pending = pending + PendWidth'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/floo_mcast_rsp_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : floo_mcast_rsp_reducer
//  Description : Collects the per-destination responses of a multicast write
//                and emits one merged response; unicast flits pass through.
//                One-entry output register, 1-cycle latency, full throughput.
//  Revision    : 1.0 - initial version
// ============================================================================
module floo_mcast_rsp_reducer
    import floo_pkg::*;
#(
    parameter int unsigned MaxDests    = 16,
    parameter int unsigned NumMcastIds = 8,
    parameter type         flit_t      = floo_pkg::flit_t,
    localparam int unsigned CntWidth   = $clog2(MaxDests + 1),
    localparam int unsigned PendWidth  = $clog2(NumMcastIds + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [CntWidth-1:0]  num_dests_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  flit_t                data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output flit_t                data_o,
    output logic [PendWidth-1:0] pending_o,
    output logic                 overflow_o
);

    localparam int unsigned IdWidth     = (NumMcastIds > 1) ? $clog2(NumMcastIds) : 1;
    localparam int unsigned CntIncWidth = CntWidth + 1;

    logic [CntWidth-1:0]    target;
    logic [IdWidth-1:0]     id;
    mcast_entry_t           entry;
    mcast_entry_t           upd_entry;
    logic [CntIncWidth-1:0] cnt_inc;
    logic                   is_mcast;
    logic                   absorb;
    logic                   overflow_hit;
    rsp_err_e               merged_err;
    logic                   slot_free;
    logic                   handshake;
    logic                   load;
    logic                   upd_en;
    logic                   clr_en;
    flit_t                  load_data;
    logic                   out_valid;
    flit_t                  out_data;
    logic                   overflow_q;

    // Effective response target: zero means "one", large values saturate.
    always_comb begin
        target = num_dests_i;
        if (num_dests_i == '0) begin
            target = CntWidth'(1);
        end else if (num_dests_i > CntWidth'(MaxDests)) begin
            target = CntWidth'(MaxDests);
        end
    end

    assign id       = IdWidth'(data_i.hdr.mcast_id);
    assign is_mcast = data_i.hdr.ring_on_mesh_mcast;

    floo_mcast_rsp_table #(
        .NumMcastIds (NumMcastIds),
        .IdWidth     (IdWidth),
        .PendWidth   (PendWidth)
    ) u_table (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lookup_id    (id),
        .lookup_entry (entry),
        .upd_en       (upd_en),
        .clr_en       (clr_en),
        .upd_id       (id),
        .upd_entry    (upd_entry),
        .pending      (pending_o)
    );

    // Classify the flit at the head of the input purely from data and table.
    always_comb begin
        cnt_inc      = CntIncWidth'(entry.cnt) + CntIncWidth'(1);
        absorb       = is_mcast && (cnt_inc < CntIncWidth'(target));
        overflow_hit = is_mcast && (CntIncWidth'(entry.cnt) >= CntIncWidth'(target));
        merged_err   = rsp_err_max(entry.err, data_i.hdr.rsp_err);
    end

    // Absorbed responses never need the output slot, so they drain even
    // while the NI stalls; everything else waits for a free slot.
    always_comb begin
        slot_free = !out_valid || ready_i;
        ready_o   = absorb || slot_free;
        handshake = valid_i && ready_o;
        load      = handshake && !absorb;
        upd_en    = handshake && absorb;
        clr_en    = handshake && is_mcast && !absorb;
    end

    // Table write data and the merged flit presented to the output register.
    always_comb begin
        upd_entry.cnt = McastCntWidth'(cnt_inc);
        upd_entry.err = merged_err;
        load_data     = data_i;
        if (is_mcast) begin
            load_data.hdr.rsp_err            = merged_err;
            load_data.hdr.ring_on_mesh_mcast = 1'b0;
        end
    end

    // Single-entry output register: load on accept, empty on drain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (ready_i) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky flag for a response arriving beyond the target count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (handshake && overflow_hit) begin
            overflow_q <= 1'b1;
        end
    end

    assign valid_o    = out_valid;
    assign data_o     = out_data;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_floo_mcast_rsp_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floo_mcast_rsp_reducer
//  Description : Self-checking bench: directed scenarios with literal
//                expectations plus randomized traffic against a per-id
//                response-count reference model.
//  Revision    : 1.0 - initial version
// ============================================================================
module tb_floo_mcast_rsp_reducer;
    import floo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  num_dests;
    logic        valid_i;
    logic        ready_o;
    flit_t       data_i;
    logic        valid_o;
    logic        ready_i;
    flit_t       data_o;
    logic [3:0]  pending;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    floo_mcast_rsp_reducer #(
        .MaxDests    (16),
        .NumMcastIds (8),
        .flit_t      (flit_t)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .num_dests_i (num_dests),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .pending_o   (pending),
        .overflow_o  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic flit_t mk(input bit mc, input int id, input int er, input logic [31:0] pl);
        flit_t f;
        f.hdr.ring_on_mesh_mcast = mc;
        f.hdr.mcast_id           = 3'(id);
        f.hdr.rsp_err            = rsp_err_e'(er[1:0]);
        f.payload                = pl;
        return f;
    endfunction

    // ---------------- reference model ----------------
    // Responses received so far and worst error, per id; expected output slot.
    int    rcv_m [8];
    int    err_m [8];
    bit    ov_m;
    flit_t od_m;
    bit    ovf_m;

    always @(negedge clk) begin : p_model
        int    t;
        int    idx;
        int    pend;
        int    worst;
        bit    exp_rdy;
        flit_t f;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rcv_m[i] = 0;
                err_m[i] = 0;
            end
            ov_m  = 1'b0;
            od_m  = '0;
            ovf_m = 1'b0;
            chk("rst_valid",    valid_o,  0);
            chk("rst_ready",    ready_o,  1);
            chk("rst_data",     data_o,   0);
            chk("rst_pending",  pending,  0);
            chk("rst_overflow", overflow, 0);
        end else begin
            t    = (num_dests == 0) ? 1 : ((num_dests > 16) ? 16 : int'(num_dests));
            idx  = int'(data_i.hdr.mcast_id);
            pend = 0;
            for (int i = 0; i < 8; i++) if (rcv_m[i] != 0) pend++;
            if (data_i.hdr.ring_on_mesh_mcast && (rcv_m[idx] + 1 < t)) exp_rdy = 1'b1;
            else exp_rdy = !ov_m || ready_i;

            chk("m_ready",    ready_o,  exp_rdy);
            chk("m_valid",    valid_o,  ov_m);
            if (ov_m) chk("m_data", data_o, od_m);
            chk("m_pending",  pending,  pend);
            chk("m_overflow", overflow, ovf_m);

            // state after the coming edge
            if (ov_m && ready_i) ov_m = 1'b0;
            if (valid_i && exp_rdy) begin
                if (!data_i.hdr.ring_on_mesh_mcast) begin
                    ov_m = 1'b1;
                    od_m = data_i;
                end else begin
                    worst = (err_m[idx] > int'(data_i.hdr.rsp_err)) ? err_m[idx] : int'(data_i.hdr.rsp_err);
                    if (rcv_m[idx] + 1 < t) begin
                        rcv_m[idx]++;
                        err_m[idx] = worst;
                    end else begin
                        if (rcv_m[idx] >= t) ovf_m = 1'b1;
                        f = data_i;
                        f.hdr.rsp_err            = rsp_err_e'(worst[1:0]);
                        f.hdr.ring_on_mesh_mcast = 1'b0;
                        od_m       = f;
                        ov_m       = 1'b1;
                        rcv_m[idx] = 0;
                        err_m[idx] = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit v, input flit_t f);
        @(posedge clk);
        #2;
        valid_i = v;
        data_i  = f;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    int    nout;
    flit_t u1;
    int    nd_tab [8] = '{0, 1, 2, 3, 4, 7, 16, 20};

    initial begin
        rst_n     = 1'b0;
        num_dests = 5'd4;
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        data_i    = '0;
        #22;
        rst_n = 1'b1;

        // T=4, id 2, errs 0,0,2,0
        do_reset();
        num_dests = 5'd4;
        ready_i   = 1'b1;
        step(1, mk(1, 2, 0, 32'h10));
        chk("t1_ready0", ready_o, 1);
        chk("t1_valid0", valid_o, 0);
        step(1, mk(1, 2, 0, 32'h11));
        chk("t1_ready1", ready_o, 1);
        chk("t1_valid1", valid_o, 0);
        chk("t1_pend1",  pending, 1);
        step(1, mk(1, 2, 2, 32'h12));
        chk("t1_ready2", ready_o, 1);
        chk("t1_valid2", valid_o, 0);
        chk("t1_pend2",  pending, 1);
        step(1, mk(1, 2, 0, 32'h13));
        chk("t1_ready3", ready_o, 1);
        chk("t1_valid3", valid_o, 0);
        chk("t1_pend3",  pending, 1);
        step(0, '0);
        chk("t1_out_valid", valid_o, 1);
        chk("t1_out_err",   data_o.hdr.rsp_err, 2);
        chk("t1_out_mcast", data_o.hdr.ring_on_mesh_mcast, 0);
        chk("t1_out_pl",    data_o.payload, 32'h13);
        chk("t1_pend4",     pending, 0);

        // NI stall: unicast held, second unicast blocked, absorb still flows
        do_reset();
        num_dests = 5'd4;
        ready_i   = 1'b0;
        u1 = mk(0, 3, 1, 32'hA5A5_0001);
        step(1, u1);
        chk("t2_ready_empty", ready_o, 1);
        step(1, mk(0, 4, 0, 32'hA5A5_0002));
        chk("t2_valid_a", valid_o, 1);
        chk("t2_data_a",  data_o, u1);
        chk("t2_blocked", ready_o, 0);
        step(1, mk(1, 1, 1, 32'hB0));
        chk("t2_absorb_ready", ready_o, 1);
        chk("t2_data_b", data_o, u1);
        step(0, '0);
        chk("t2_data_c", data_o, u1);
        chk("t2_valid_c", valid_o, 1);
        chk("t2_pend", pending, 1);
        ready_i = 1'b1;
        step(0, '0);
        chk("t2_drained", valid_o, 0);

        // Interleaved ids 0 and 5, T=2
        do_reset();
        num_dests = 5'd2;
        step(1, mk(1, 0, 1, 32'h20));
        step(1, mk(1, 5, 0, 32'h21));
        step(1, mk(1, 0, 0, 32'h22));
        chk("t3_none", valid_o, 0);
        step(1, mk(1, 5, 3, 32'h23));
        chk("t3_o0_valid", valid_o, 1);
        chk("t3_o0_id",    data_o.hdr.mcast_id, 0);
        chk("t3_o0_err",   data_o.hdr.rsp_err, 1);
        step(0, '0);
        chk("t3_o5_valid", valid_o, 1);
        chk("t3_o5_id",    data_o.hdr.mcast_id, 5);
        chk("t3_o5_err",   data_o.hdr.rsp_err, 3);
        chk("t3_pend",     pending, 0);

        // T==1 via num_dests 0 and 1
        for (int k = 0; k < 2; k++) begin
            do_reset();
            num_dests = 5'(k);
            step(1, mk(1, 4, 2, 32'h40 + k));
            step(0, '0);
            chk("t4_valid", valid_o, 1);
            chk("t4_mcast", data_o.hdr.ring_on_mesh_mcast, 0);
            chk("t4_err",   data_o.hdr.rsp_err, 2);
            chk("t4_pl",    data_o.payload, 32'h40 + k);
            chk("t4_pend",  pending, 0);
        end

        // Async reset mid-collection
        do_reset();
        num_dests = 5'd4;
        step(1, mk(1, 3, 1, 32'h50));
        step(1, mk(1, 3, 0, 32'h51));
        step(1, mk(0, 0, 0, 32'h52));
        step(0, '0);
        chk("t5_valid_pre", valid_o, 1);
        chk("t5_pend_pre",  pending, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_valid_rst", valid_o, 0);
        chk("t5_pend_rst",  pending, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        nout  = 0;
        for (int k = 0; k < 7; k++) begin
            step(k < 4, mk(1, 3, 0, 32'h60 + k));
            nout += int'(valid_o);
        end
        chk("t5_one_output", nout, 1);

        // Illegal target reduction -> overflow
        do_reset();
        num_dests = 5'd4;
        step(1, mk(1, 6, 1, 32'h70));
        step(1, mk(1, 6, 0, 32'h71));
        step(1, mk(1, 6, 0, 32'h72));
        @(posedge clk);
        #2;
        num_dests = 5'd2;
        valid_i   = 1'b1;
        data_i    = mk(1, 6, 3, 32'h73);
        #1;
        chk("t6_pend_pre", pending, 1);
        chk("t6_no_ovf",   overflow, 0);
        step(0, '0);
        chk("t6_ovf",   overflow, 1);
        chk("t6_valid", valid_o, 1);
        chk("t6_err",   data_o.hdr.rsp_err, 3);
        chk("t6_mcast", data_o.hdr.ring_on_mesh_mcast, 0);
        chk("t6_pend",  pending, 0);
        step(0, '0);
        chk("t6_sticky", overflow, 1);

        // Randomized traffic, constant target per phase
        for (int p = 0; p < 8; p++) begin
            do_reset();
            num_dests = 5'(nd_tab[p]);
            for (int c = 0; c < 400; c++) begin
                @(posedge clk);
                #2;
                valid_i = ($urandom_range(0, 3) != 0);
                ready_i = ($urandom_range(0, 2) != 0);
                data_i  = mk(($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
                             int'($urandom_range(0, 3)), $urandom);
            end
            @(posedge clk);
            #2;
            valid_i = 1'b0;
            ready_i = 1'b1;
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
